// File: rtl/tape_pkg.sv
// ---------------------------------------------------------------------------
// tape_pkg
// Shared constants and helpers for the tape pulse capture path.
//
// A pulse word is 16 bits:
//   [15]   level of the tape signal during the measured pulse
//   [14:0] pulse length in prescaler ticks, saturating at TAPE_CNT_MAX
//
// The CPU reads a word as two bytes, low byte first.
// ---------------------------------------------------------------------------
package tape_pkg;

    localparam int TAPE_CNT_W  = 15;
    localparam int TAPE_WORD_W = 16;

    localparam logic [TAPE_CNT_W-1:0] TAPE_CNT_MAX = 15'h7FFF;

    // Field offsets inside a pulse word
    localparam int TAPE_LEVEL_BIT = 15;
    localparam int TAPE_CNT_LSB   = 0;

    // Byte lanes used by the CPU read port
    localparam int TAPE_LO_BYTE_LSB = 0;
    localparam int TAPE_HI_BYTE_LSB = 8;

    typedef logic [TAPE_WORD_W-1:0] tape_word_t;

    // Packs a level and a pulse length into a FIFO word.
    function automatic tape_word_t make_pulse_word(
        input logic                  level,
        input logic [TAPE_CNT_W-1:0] count
    );
        tape_word_t w;
        w                                 = '0;
        w[TAPE_LEVEL_BIT]                 = level;
        w[TAPE_CNT_LSB +: TAPE_CNT_W]     = count;
        return w;
    endfunction

endpackage

// File: rtl/tape_word_fifo.sv
// ---------------------------------------------------------------------------
// tape_word_fifo
// Synchronous single-clock FIFO holding pulse words.
//
// Parameters:
//   DEPTH  number of words, power of two
//   WIDTH  word width in bits
//
// Ports:
//   i_clock    system clock
//   i_reset    synchronous active-high reset
//   i_clear    synchronous flush, wins over push and pop
//   i_push     write i_wr_data at the tail (ignored when full unless popping)
//   i_pop      drop the head word (ignored when empty)
//   i_wr_data  word to write
//   o_rd_data  current head word (valid while o_count != 0)
//   o_count    number of words stored, registered
// ---------------------------------------------------------------------------
module tape_word_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             is_empty;
    logic             is_full;
    logic             do_push;
    logic             do_pop;

    assign is_empty = (count == '0);
    assign is_full  = (count == (PTR_W+1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO can still
    // accept a push when it is being popped at the same time.
    assign do_pop  = i_pop && !is_empty && !i_clear;
    assign do_push = i_push && (!is_full || do_pop) && !i_clear;

    assign o_rd_data = mem[rd_ptr];
    assign o_count   = count;

    // Storage array; contents need no reset because the count gates reads.
    always_ff @(posedge i_clock) begin
        if (do_push) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and word count. Pointers wrap naturally since DEPTH is a
    // power of two.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tape_pulse_fifo.sv
// ---------------------------------------------------------------------------
// tape_pulse_fifo
// Measures the length of each pulse on the tape/EAR input and queues it as
// a 16-bit word {level, ticks} for the CPU, which reads it a byte at a time.
//
// Parameters:
//   DEPTH            FIFO depth in words (power of two, 4..256)
//   PRESCALE_NORMAL  clocks per tick in normal load mode
//   PRESCALE_TURBO   clocks per tick in turbo load mode
//
// Ports:
//   i_clock       system clock
//   i_reset       synchronous active-high reset
//   i_tape_in     raw tape level, asynchronous to i_clock
//   i_clear_fifo  flush FIFO, byte select, overflow flag and pulse counter
//   i_load_turbo  1 selects the turbo tick rate
//   i_rd_strobe   one-cycle CPU read pulse; the high-byte read pops a word
//   o_data        byte currently presented to the CPU (0x00 when empty)
//   o_empty       FIFO holds no words
//   o_full        FIFO holds DEPTH words
//   o_overflow    sticky flag: a pulse word was dropped
//
// Build option:
//   TAPE_PULSE_TIMEOUT_EN  when defined, a pulse that saturates the counter
//                          pushes one {level, 0x7FFF} word without waiting
//                          for the next edge.
// ---------------------------------------------------------------------------
module tape_pulse_fifo #(
    parameter int DEPTH           = 32,
    parameter int PRESCALE_NORMAL = 16,
    parameter int PRESCALE_TURBO  = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_tape_in,
    input  logic       i_clear_fifo,
    input  logic       i_load_turbo,
    input  logic       i_rd_strobe,
    output logic [7:0] o_data,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_overflow
);

    import tape_pkg::*;

    localparam int PS_MAX  = (PRESCALE_NORMAL > PRESCALE_TURBO) ? PRESCALE_NORMAL
                                                                : PRESCALE_TURBO;
    localparam int PS_W    = $clog2(PS_MAX + 1);
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    logic                  sync_1;
    logic                  sync_2;
    logic                  prev_level;
    logic                  tape_edge;

    logic                  turbo_q;
    logic                  mode_change;
    logic [PS_W-1:0]       ps_cnt;
    logic [PS_W-1:0]       ps_limit;
    logic                  tick;

    logic [TAPE_CNT_W-1:0] pulse_cnt;
    logic                  timeout_push;

    logic                  push;
    logic                  pop;
    tape_word_t            push_word;
    tape_word_t            head_word;
    logic [COUNT_W-1:0]    word_count;
    logic                  fifo_empty;
    logic                  fifo_full;

    logic                  byte_sel;
    logic                  overflow;

    // Two-flop synchronizer for the asynchronous tape input, followed by a
    // third flop holding last cycle's level. Any difference between the
    // synchronized level and that previous level is a pulse boundary.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            prev_level <= 1'b0;
        end else begin
            sync_1     <= i_tape_in;
            sync_2     <= sync_1;
            prev_level <= sync_2;
        end
    end

    assign tape_edge = sync_2 ^ prev_level;

    // Tick prescaler. It counts 0..limit and ticks on the terminal value.
    // Switching between normal and turbo restarts it at 0 so the first
    // tick at the new rate is a full period away; no tick is issued in
    // the switching cycle itself.
    assign ps_limit    = i_load_turbo ? PS_W'(PRESCALE_TURBO - 1)
                                      : PS_W'(PRESCALE_NORMAL - 1);
    assign mode_change = (i_load_turbo != turbo_q);
    assign tick        = !mode_change && (ps_cnt == ps_limit);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ps_cnt  <= '0;
            turbo_q <= i_load_turbo;
        end else begin
            turbo_q <= i_load_turbo;
            if (mode_change || tick) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + PS_W'(1);
            end
        end
    end

    // Pulse length counter. An edge closes the current pulse: its word is
    // built from the count before any tick in that same cycle, and the
    // counter restarts from zero for the next pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear_fifo) begin
            pulse_cnt <= '0;
        end else if (tape_edge) begin
            pulse_cnt <= '0;
        end else if (tick && (pulse_cnt != TAPE_CNT_MAX)) begin
            pulse_cnt <= pulse_cnt + TAPE_CNT_W'(1);
        end
    end

`ifdef TAPE_PULSE_TIMEOUT_EN
    logic timeout_done;

    // A saturated pulse is reported once; the flag blocks repeats until the
    // next edge starts a fresh pulse.
    assign timeout_push = !tape_edge && !timeout_done && (pulse_cnt == TAPE_CNT_MAX);

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear_fifo || tape_edge) begin
            timeout_done <= 1'b0;
        end else if (timeout_push) begin
            timeout_done <= 1'b1;
        end
    end
`else
    assign timeout_push = 1'b0;
`endif

    // Both edge and timeout words carry the level that was held during the
    // pulse and the current count (which is 0x7FFF in the timeout case).
    assign push_word = make_pulse_word(prev_level, pulse_cnt);
    assign push      = !i_clear_fifo && (tape_edge || timeout_push);

    // Only the strobe that consumes the high byte removes the word.
    assign pop = !i_clear_fifo && i_rd_strobe && !fifo_empty && byte_sel;

    tape_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TAPE_WORD_W)
    ) u_word_fifo (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (i_clear_fifo),
        .i_push    (push),
        .i_pop     (pop),
        .i_wr_data (push_word),
        .o_rd_data (head_word),
        .o_count   (word_count)
    );

    assign fifo_empty = (word_count == '0);
    assign fifo_full  = (word_count == COUNT_W'(DEPTH));

    // Byte select flips on every strobe that finds data; strobes against
    // an empty FIFO leave it untouched so the next word starts low byte.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear_fifo) begin
            byte_sel <= 1'b0;
        end else if (i_rd_strobe && !fifo_empty) begin
            byte_sel <= ~byte_sel;
        end
    end

    // Sticky overflow: set when a word had nowhere to go. A push into a
    // full FIFO that is popped in the same cycle is accepted, not dropped.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear_fifo) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // CPU-visible byte; reads as zero whenever there is nothing queued.
    always_comb begin
        o_data = 8'h00;
        if (!fifo_empty) begin
            if (byte_sel) begin
                o_data = head_word[TAPE_HI_BYTE_LSB +: 8];
            end else begin
                o_data = head_word[TAPE_LO_BYTE_LSB +: 8];
            end
        end
    end

    assign o_empty    = fifo_empty;
    assign o_full     = fifo_full;
    assign o_overflow = overflow;

endmodule
